// File: rtl/tinker_fetch_pkg.sv
// Shared types and constants for the tinker instruction-fetch queue.
package tinker_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 64;

  localparam logic [ADDR_W-1:0] TINKER_RESET_PC = 64'h2000;
  localparam logic [ADDR_W-1:0] PC_STEP         = 64'd4;

  // One buffered fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/tinker_fq_fifo.sv
// Registered FIFO of fetched instructions. No bypass: a pushed entry becomes
// visible at the head one cycle later. Flush wins over push and pop.
module tinker_fq_fifo
  import tinker_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fq_entry_t              push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output fq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tinker_fetch_queue.sv
// Decoupled instruction-fetch stage: issues sequential fetches, buffers the
// returned words with their PCs, and handles control-flow redirects.
// Optional statistics counters are built when TINKER_FQ_STATS_EN is defined.
module tinker_fetch_queue
  import tinker_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = TINKER_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_W-1:0]      imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INST_W-1:0]      imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INST_W-1:0]      inst_data,
  output logic [ADDR_W-1:0]      inst_pc,
  output logic [$clog2(DEPTH):0] fq_count
`ifdef TINKER_FQ_STATS_EN
  ,
  output logic [31:0]            stat_drop_cnt,
  output logic [31:0]            stat_starve_cnt,
  output logic [31:0]            stat_full_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]     outstanding_q, outstanding_d;
  logic [OW-1:0]     drop_cnt_q, drop_cnt_d;

  logic      req_fire, resp_keep, resp_drop, inst_pop;
  logic      fifo_full, fifo_empty;
  fq_entry_t push_entry, head;
  logic [CW-1:0] count;

  // Credit check counts in-flight fetches as reserved FIFO slots, so a kept
  // response always finds room.
  assign imem_req_valid = !reset && !redirect_valid
                          && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
                          && ((32'(count) + 32'(outstanding_q)) < 32'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses that were in flight at a redirect, or arrive with it, are stale.
  assign resp_drop  = imem_resp_valid && (redirect_valid || (drop_cnt_q != '0));
  assign resp_keep  = imem_resp_valid && !resp_drop;
  assign push_entry = '{pc: resp_pc_q, inst: imem_resp_data};

  assign inst_valid = !fifo_empty;
  assign inst_pop   = inst_valid && inst_ready;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign fq_count   = count;

  tinker_fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (resp_keep),
    .push_data_i (push_entry),
    .pop_i       (inst_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .count_o     (count)
  );

  // Next-state for PCs and the in-flight / drop bookkeeping; redirect wins.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_resp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = outstanding_q - OW'(imem_resp_valid);
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + PC_STEP;
      if (resp_keep) resp_pc_d  = resp_pc_q + PC_STEP;
      if (resp_drop) drop_cnt_d = drop_cnt_q - OW'(1);
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // A kept response into a full FIFO means memory broke the credit contract.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(resp_keep && fifo_full && !inst_pop));
  end

`ifdef TINKER_FQ_STATS_EN
  logic [31:0] stat_drop_q, stat_starve_q, stat_full_q;

  // Saturating event counters; redirects do not clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_drop_q   <= '0;
      stat_starve_q <= '0;
      stat_full_q   <= '0;
    end else begin
      if (resp_drop && (stat_drop_q != '1))                  stat_drop_q   <= stat_drop_q + 32'd1;
      if (inst_ready && !inst_valid && (stat_starve_q != '1)) stat_starve_q <= stat_starve_q + 32'd1;
      if (fifo_full && (stat_full_q != '1))                  stat_full_q   <= stat_full_q + 32'd1;
    end
  end

  assign stat_drop_cnt   = stat_drop_q;
  assign stat_starve_cnt = stat_starve_q;
  assign stat_full_cnt   = stat_full_q;
`endif

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Self-checking bench for tinker_fetch_queue. A behavioural memory returns
// word = low 32 bits of the address with 1..3 cycle in-order latency; the
// reference model is simply "the next instruction is at the expected PC",
// restarting at every redirect target.
module tb_tinker_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h2000;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic [2:0]  fq_count;
`ifdef TINKER_FQ_STATS_EN
  logic [31:0] stat_drop_cnt, stat_starve_cnt, stat_full_cnt;
`endif

  tinker_fetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .fq_count        (fq_count)
`ifdef TINKER_FQ_STATS_EN
    ,
    .stat_drop_cnt   (stat_drop_cnt),
    .stat_starve_cnt (stat_starve_cnt),
    .stat_full_cnt   (stat_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        mq[$];
  int unsigned cyc, ready_pct, lat_min, lat_max, n_req, popped;
  int          inflight, first_req_cyc, first_val_cyc;
  logic [63:0] exp_pc, first_after;
  logic        watch_redir;
  int          checks, errors;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, sample 1 ns later, update models.
  task automatic step(input logic redir, input logic [63:0] rpc, input logic iready);
    logic        resp_now;
    int unsigned due;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = iready;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    resp_now       = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_resp_valid = resp_now;
    if (resp_now) imem_resp_data = mq[0].data;
    else          imem_resp_data = $urandom;
    #1;
    check_eq("inst_valid_vs_count", inst_valid, fq_count != 0);
    check_eq("credit_bound", (int'(fq_count) + inflight) <= int'(DEPTH), 1);
    check_eq("outstanding_bound", inflight <= int'(MAXO), 1);
    if (redir) check_eq("no_req_on_redirect", imem_req_valid, 0);
    if (inst_valid && inst_ready) begin
      check_eq("inst_pc", inst_pc, exp_pc);
      check_eq("inst_data", inst_data, {32'h0, exp_pc[31:0]});
      if (watch_redir) begin
        first_after = inst_pc;
        watch_redir = 1'b0;
      end
      exp_pc = exp_pc + 64'd4;
      popped++;
    end
    if (redir) begin
      exp_pc      = rpc;
      watch_redir = 1'b1;
    end
    if (first_req_cyc < 0 && imem_req_valid && imem_req_ready) first_req_cyc = int'(cyc);
    if (first_val_cyc < 0 && inst_valid) first_val_cyc = int'(cyc);
    if (resp_now) begin
      void'(mq.pop_front());
      inflight--;
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (mq.size() != 0 && due <= mq[$].due) due = mq[$].due + 1;
      mq.push_back('{due, imem_req_addr[31:0]});
      inflight++;
      n_req++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    mq.delete();
    inflight      = 0;
    exp_pc        = RPC;
    watch_redir   = 1'b0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    #1;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_fq_count", fq_count, 0);
`ifdef TINKER_FQ_STATS_EN
    check_eq("rst_stat_drop", stat_drop_cnt, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned p0, r0;
    logic [31:0] s0;
    clk = 1'b0; reset = 1'b0; imem_resp_data = '0;
    checks = 0; errors = 0; cyc = 0; n_req = 0; popped = 0; first_after = '0;
    ready_pct = 100; lat_min = 1; lat_max = 1;

    // Streaming from reset with a single-cycle memory.
    do_reset();
    p0 = popped;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    check_eq("first_inst_latency",
             (first_req_cyc >= 0) && (first_val_cyc >= 0) && (first_val_cyc - first_req_cyc <= 3), 1);
    check_eq("steady_pops", popped - p0, 10);

    // Stalled decode fills the FIFO; one pop frees exactly one request.
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    check_eq("full_count", fq_count, DEPTH);
    check_eq("full_req_valid", imem_req_valid, 0);
    check_eq("full_inflight", inflight, 0);
    r0 = n_req;
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    check_eq("one_refill_req", n_req - r0, 1);

    // Redirect with two fetches in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && inflight < 2; i++) step(1'b0, '0, 1'b1);
    check_eq("two_in_flight", inflight, 2);
`ifdef TINKER_FQ_STATS_EN
    s0 = stat_drop_cnt;
`endif
    step(1'b1, 64'h3000, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    check_eq("redir_first_pc", first_after, 64'h3000);
`ifdef TINKER_FQ_STATS_EN
    check_eq("stat_drop_delta", stat_drop_cnt - s0, 2);
`endif

    // Redirect coinciding with a response and a pop; misaligned target.
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    check_eq("coincide_setup", (mq.size() != 0) && (mq[0].due <= cyc) && inst_valid, 1);
    step(1'b1, 64'h5002, 1'b1);
    check_eq("flush_count", fq_count, 0);
    check_eq("flush_valid", inst_valid, 0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check_eq("coincide_first_pc", first_after, 64'h5002);

    // Back-to-back redirects: the last wins, and its PCs wrap past 2^64.
    step(1'b1, 64'h7000, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check_eq("last_redirect_wins", first_after, 64'hFFFF_FFFF_FFFF_FFF8);

`ifdef TINKER_FQ_STATS_EN
    // Decode waits on an empty FIFO for five cycles.
    do_reset();
    ready_pct = 0;
    s0 = stat_starve_cnt;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    check_eq("stat_starve_delta", stat_starve_cnt - s0, 5);
    ready_pct = 100;
`endif

    // Randomised traffic with occasional redirects.
    do_reset();
    ready_pct = 50; lat_min = 1; lat_max = 3;
    p0 = popped;
    for (int i = 0; i < 20000 && (popped - p0) < 1000; i++)
      step($urandom_range(99) == 0, {$urandom, $urandom} & ~64'h3, $urandom_range(3) != 0);
    check_eq("random_1000_done", (popped - p0) >= 1000, 1);

    // Reset in the middle of traffic returns everything to reset values.
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
